// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32I core: opcode classification,
// datapath sequencing, memory handshake and retired-instruction count.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic [2:0]       instr_type,
  output logic [2:0]       state,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_src,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_OP, C_OPIMM, C_LOAD, C_JALR, C_STORE,
    C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_NONE
  } cls_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  state_t     cur, nxt;
  cls_t       cls, dec_cls;
  logic [2:0] dec_type;
  logic [6:0] opc;
  logic       retire;
  logic       unused_bits;

  assign opc         = instr[6:0];
  assign unused_bits = ^instr[31:7];
  assign state       = cur;

  // Opcode decode only feeds registers and the DECODE next-state choice
  always_comb begin
    dec_cls  = C_NONE;
    dec_type = 3'd0;
    unique case (1'b1)
      (opc == OPC_OP):     begin dec_cls = C_OP;     dec_type = 3'd0; end
      (opc == OPC_OPIMM):  begin dec_cls = C_OPIMM;  dec_type = 3'd1; end
      (opc == OPC_LOAD):   begin dec_cls = C_LOAD;   dec_type = 3'd1; end
      (opc == OPC_JALR):   begin dec_cls = C_JALR;   dec_type = 3'd1; end
      (opc == OPC_STORE):  begin dec_cls = C_STORE;  dec_type = 3'd2; end
      (opc == OPC_BRANCH): begin dec_cls = C_BRANCH; dec_type = 3'd3; end
      (opc == OPC_LUI):    begin dec_cls = C_LUI;    dec_type = 3'd4; end
      (opc == OPC_AUIPC):  begin dec_cls = C_AUIPC;  dec_type = 3'd4; end
      (opc == OPC_JAL):    begin dec_cls = C_JAL;    dec_type = 3'd5; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur           <= S_FETCH;
      cls           <= C_OP;
      instr_type    <= 3'd0;
      illegal       <= 1'b0;
      retired_count <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) begin
        cls        <= dec_cls;
        instr_type <= dec_type;
        if (dec_cls == C_NONE) illegal <= 1'b1;
      end
      if (retire) retired_count <= retired_count + 1'b1;
    end
  end

  always_comb begin
    nxt          = cur;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_src = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    retire       = 1'b0;
    unique case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          nxt      = S_DECODE;
        end
      end
      S_DECODE: nxt = (dec_cls == C_NONE) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        alu_src_a = (cls == C_AUIPC);
        alu_src_b = !(cls == C_OP || cls == C_BRANCH);
        unique case (cls)
          C_LOAD, C_STORE: nxt = S_MEM;
          C_BRANCH: begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'd1 : 2'd0;
            retire   = 1'b1;
            nxt      = S_FETCH;
          end
          default: nxt = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_src = 1'b1;
        mem_we       = (cls == C_STORE);
        if (mem_ready) begin
          if (cls == C_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            nxt      = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        nxt       = S_FETCH;
        unique case (cls)
          C_LOAD:        wb_sel = 2'd1;
          C_JAL, C_JALR: wb_sel = 2'd2;
          C_LUI:         wb_sel = 2'd3;
          default:       wb_sel = 2'd0;
        endcase
        unique case (cls)
          C_JAL:   pc_src = 2'd1;
          C_JALR:  pc_src = 2'd2;
          default: pc_src = 2'd0;
        endcase
      end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
    // Reset aborts the instruction: no strobe, no retire
    if (reset) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected output
// snapshots are queued by the stimulus and popped by a negedge monitor.
module tb_multicycle_control;

  localparam int CW = 3;

  typedef struct packed {
    logic [2:0]    st;
    logic [2:0]    it;
    logic          irw;
    logic          pcw;
    logic [1:0]    pcs;
    logic          mrq;
    logic          mwe;
    logic          mas;
    logic          asa;
    logic          asb;
    logic          rgw;
    logic [1:0]    wbs;
    logic          ill;
    logic [CW-1:0] rc;
  } snap_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   instr = 32'd0;
  logic          mem_ready = 1'b0;
  logic          branch_taken = 1'b0;
  logic [2:0]    instr_type, state;
  logic          ir_write, pc_write, mem_req, mem_we, mem_addr_src;
  logic          alu_src_a, alu_src_b, reg_write, illegal;
  logic [1:0]    pc_src, wb_sel;
  logic [CW-1:0] retired_count;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .instr_type(instr_type), .state(state),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_src(mem_addr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  snap_t act;
  assign act = {state, instr_type, ir_write, pc_write, pc_src,
                mem_req, mem_we, mem_addr_src, alu_src_a, alu_src_b,
                reg_write, wb_sel, illegal, retired_count};

  snap_t exq[$];
  string nmq[$];
  int    checks = 0;
  int    passed = 0;

  logic [2:0]    it_e = 3'd0;
  logic [CW-1:0] rc_e = '0;
  logic          ill_e = 1'b0;

  always @(negedge clk) begin
    if (exq.size() > 0) begin
      snap_t e;
      string n;
      e = exq.pop_front();
      n = nmq.pop_front();
      checks++;
      if (act === e) passed++;
      else $display("FAIL %s: got=%h exp=%h (st %0d/%0d it %0d/%0d rc %0d/%0d)",
                    n, act, e, act.st, e.st, act.it, e.it, act.rc, e.rc);
    end
  end

  function automatic snap_t bs(logic [2:0] st);
    snap_t s;
    s = '0;
    s.st = st;
    s.it = it_e;
    s.ill = ill_e;
    s.rc = rc_e;
    return s;
  endfunction

  task automatic cyc(string nm, logic mr, logic bt, snap_t e);
    mem_ready = mr;
    branch_taken = bt;
    exq.push_back(e);
    nmq.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(string nm, int waits);
    snap_t e;
    for (int i = 0; i < waits; i++) begin
      e = bs(3'd0);
      e.mrq = 1'b1;
      cyc({nm, "_fwait"}, 1'b0, 1'b0, e);
    end
    e = bs(3'd0);
    e.mrq = 1'b1;
    e.irw = 1'b1;
    cyc({nm, "_fetch"}, 1'b1, 1'b0, e);
  endtask

  task automatic decode(string nm, logic [2:0] it);
    cyc({nm, "_decode"}, 1'b1, 1'b0, bs(3'd1));
    it_e = it;
  endtask

  task automatic ex(string nm, logic asa, logic asb);
    snap_t e;
    e = bs(3'd2);
    e.asa = asa;
    e.asb = asb;
    cyc({nm, "_exec"}, 1'b1, 1'b0, e);
  endtask

  task automatic wb(string nm, logic [1:0] wbs, logic [1:0] pcs);
    snap_t e;
    e = bs(3'd4);
    e.rgw = 1'b1;
    e.pcw = 1'b1;
    e.wbs = wbs;
    e.pcs = pcs;
    cyc({nm, "_wb"}, 1'b1, 1'b0, e);
    rc_e = rc_e + 1'b1;
  endtask

  task automatic mem(string nm, int waits, logic st);
    snap_t e;
    for (int i = 0; i < waits; i++) begin
      e = bs(3'd3);
      e.mrq = 1'b1;
      e.mas = 1'b1;
      e.mwe = st;
      cyc({nm, "_mwait"}, 1'b0, 1'b0, e);
    end
    e = bs(3'd3);
    e.mrq = 1'b1;
    e.mas = 1'b1;
    e.mwe = st;
    e.pcw = st;
    cyc({nm, "_mem"}, 1'b1, 1'b0, e);
    if (st) rc_e = rc_e + 1'b1;
  endtask

  task automatic branch(string nm, logic bt);
    snap_t e;
    instr = 32'h00208463;
    fetch(nm, 0);
    decode(nm, 3'd3);
    e = bs(3'd2);
    e.pcw = 1'b1;
    e.pcs = bt ? 2'd1 : 2'd0;
    cyc({nm, "_exec"}, 1'b1, bt, e);
    rc_e = rc_e + 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    cyc("reset", 1'b1, 1'b0, bs(3'd0));
    reset = 1'b0;

    // SW aborted by reset in MEM with mem_ready high
    instr = 32'h0020A023;
    fetch("sw_abort", 0);
    decode("sw_abort", 3'd2);
    ex("sw_abort", 1'b0, 1'b1);
    reset = 1'b1;
    it_e = 3'd0;
    cyc("sw_abort_rst", 1'b1, 1'b0, bs(3'd0));
    cyc("sw_abort_rst2", 1'b1, 1'b0, bs(3'd0));
    reset = 1'b0;

    instr = 32'h00500093;
    fetch("addi", 0);
    decode("addi", 3'd1);
    ex("addi", 1'b0, 1'b1);
    wb("addi", 2'd0, 2'd0);

    instr = 32'h0000A103;
    fetch("lw", 0);
    decode("lw", 3'd1);
    ex("lw", 1'b0, 1'b1);
    mem("lw", 2, 1'b0);
    wb("lw", 2'd1, 2'd0);

    branch("beq_t", 1'b1);
    branch("beq_nt", 1'b0);

    instr = 32'h008000EF;
    fetch("jal", 0);
    decode("jal", 3'd5);
    ex("jal", 1'b0, 1'b1);
    wb("jal", 2'd2, 2'd1);

    instr = 32'h000080E7;
    fetch("jalr", 0);
    decode("jalr", 3'd1);
    ex("jalr", 1'b0, 1'b1);
    wb("jalr", 2'd2, 2'd2);

    instr = 32'h123450B7;
    fetch("lui", 0);
    decode("lui", 3'd4);
    ex("lui", 1'b0, 1'b1);
    wb("lui", 2'd3, 2'd0);

    // Counter sits at all-ones here; this retire wraps it to 0
    instr = 32'h00001097;
    fetch("auipc", 0);
    decode("auipc", 3'd4);
    ex("auipc", 1'b1, 1'b1);
    wb("auipc", 2'd0, 2'd0);

    instr = 32'h002081B3;
    fetch("add", 1);
    decode("add", 3'd0);
    ex("add", 1'b0, 1'b0);
    wb("add", 2'd0, 2'd0);

    instr = 32'h0020A023;
    fetch("sw", 0);
    decode("sw", 3'd2);
    ex("sw", 1'b0, 1'b1);
    mem("sw", 1, 1'b1);

    instr = 32'h0000007F;
    fetch("ill", 0);
    decode("ill", 3'd0);
    ill_e = 1'b1;
    for (int i = 0; i < 20; i++) cyc("ill_trap", 1'b1, 1'b0, bs(3'd5));

    reset = 1'b1;
    it_e = 3'd0;
    ill_e = 1'b0;
    rc_e = '0;
    cyc("ill_reset", 1'b1, 1'b0, bs(3'd0));
    reset = 1'b0;
    instr = 32'h00500093;
    fetch("restart", 1);

    @(negedge clk);
    checks++;
    if (exq.size() == 0) passed++;
    else $display("FAIL drain: got=%0d pending exp=0", exq.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the RV32I core.
- Decodes the opcode held in the instruction register and classifies the instruction into the instr_type code consumed by the immediate generator.
- Sequences fetch, decode, execute, memory and writeback by driving datapath mux selects, write strobes and a single-port memory request/ready handshake.
- Keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired_count (wraps modulo 2^CNT_W)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
instr  in  32  instruction register contents; valid from DECODE onward
mem_ready  in  1  memory completes the current request this cycle
branch_taken  in  1  branch comparison result from the ALU; valid in EXEC
instr_type  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; registered
state  out  3  0=FETCH, 1=DECODE, 2=EXEC, 3=MEM, 4=WB, 5=TRAP
ir_write  out  1  load the instruction register
pc_write  out  1  update the PC
pc_src  out  2  0=pc+4, 1=pc+imm, 2=alu_out
mem_req  out  1  memory request
mem_we  out  1  request is a write
mem_addr_src  out  1  0=PC, 1=alu_out
alu_src_a  out  1  0=rs1, 1=PC
alu_src_b  out  1  0=rs2, 1=imm
reg_write  out  1  write the register file
wb_sel  out  2  0=alu_out, 1=mem data, 2=pc+4, 3=imm
illegal  out  1  sticky illegal-opcode flag
retired_count  out  CNT_W  number of retired instructions

Behaviour:
- Reset:
  - state=FETCH, instr_type=0, illegal=0, retired_count=0.
  - While reset is high, every strobe (ir_write, pc_write, mem_req, mem_we, reg_write) is forced to 0.
  - Mid-operation reset aborts the instruction immediately: no strobe is issued and the counter is not incremented.
- Output timing:
  - Strobes and selects decode from the registered state and the registered opcode class only.
  - The exceptions are ir_write, the MEM exit strobes and pc_src in EXEC, which also depend on mem_ready and branch_taken as stated below.
  - No combinational path runs from instr to any output.
  - Selects not listed for a state are 0.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_src=0.
  - If mem_ready=1: ir_write=1 and go to DECODE.
  - Otherwise hold with mem_req high.
- DECODE:
  - Register the opcode class and instr_type from instr[6:0]:
    - 0110011 OP is R.
    - 0010011 OP-IMM, 0000011 LOAD and 1100111 JALR are I.
    - 0100011 STORE is S.
    - 1100011 BRANCH is B.
    - 0110111 LUI and 0010111 AUIPC are U.
    - 1101111 JAL is J.
  - Any other opcode: illegal=1, instr_type=0, go to TRAP.
  - Otherwise go to EXEC.
- EXEC:
  - alu_src_a=1 for AUIPC only.
  - alu_src_b=1 for everything except OP and BRANCH.
  - LOAD/STORE go to MEM.
  - BRANCH: pc_write=1, pc_src = branch_taken ? 1 : 0, retire, go to FETCH.
  - All other classes go to WB.
- MEM:
  - mem_req=1, mem_addr_src=1, mem_we=1 for STORE.
  - Hold until mem_ready.
  - On ready, STORE: pc_write=1, pc_src=0, retire, go to FETCH.
  - On ready, LOAD: go to WB.
- WB:
  - reg_write=1, pc_write=1, retire, go to FETCH.
  - wb_sel: OP/OP-IMM/AUIPC=0, LOAD=1, JAL/JALR=2, LUI=3.
  - pc_src: JAL=1, JALR=2, else 0.
  - The datapath holds alu_out from EXEC.
- TRAP: all strobes 0 and illegal=1 until reset; no further fetch.
- Retire: retired_count increments by 1 on the clock edge that ends a retiring cycle; it wraps from all-ones to 0.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle):
  - BRANCH: 3 cycles.
  - STORE and ALU/U/J instructions: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- Simultaneous events: reset dominates everything. In FETCH or MEM, mem_ready is sampled only while mem_req=1.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready=1 always -> states 0,1,2,4,0; instr_type=1; alu_src_b=1 in EXEC; reg_write=1, wb_sel=0, pc_src=0 in WB; retired_count 0->1 after 4 cycles.
- LW (0x0000A103) with mem_ready low for 2 MEM cycles -> mem_req=1 and mem_addr_src=1 held 3 cycles in MEM; WB wb_sel=1; total 7 cycles.
- BEQ, taken and not-taken:
  - branch_taken=1 -> EXEC pc_write=1, pc_src=1, 3 cycles, instr_type=3.
  - branch_taken=0 -> pc_src=0.
- JAL (0x008000EF) -> instr_type=5; WB reg_write=1, wb_sel=2, pc_src=1. JALR -> instr_type=1, pc_src=2.
- Illegal opcode 0x0000007F -> illegal=1 and state=5 after DECODE; no mem_req for 20 cycles; reset clears illegal and restarts FETCH.
- Reset asserted in MEM of SW with mem_ready=1 in the same cycle -> mem_we/pc_write never pulse, retired_count unchanged at 0, state=0; counter forced to all-ones wraps to 0 on the next retire.
